// File: rtl/mem_access_ctrl.sv
// Sequences one MAR/MDR memory transaction: address load, data load, wait states, done.
// All strobes are Moore outputs decoded from the registered state and wait counter.
module mem_access_ctrl #(
  parameter int MEM_LATENCY = 2,
  parameter int CNT_W       = 8
) (
  input  logic clock,
  input  logic clear,
  input  logic start,
  input  logic rw,
  output logic busy,
  output logic done,
  output logic MARin,
  output logic MDRin,
  output logic read,
  output logic mem_read,
  output logic mem_write,
  output logic MDRout
);

  typedef enum logic [2:0] {
    IDLE, LOAD_MAR, RD_WAIT, RD_DONE, WR_LOAD, WR_WAIT, WR_DONE
  } state_t;

  localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(MEM_LATENCY - 1);

  state_t           state, state_nxt;
  logic [CNT_W-1:0] cnt, cnt_nxt;
  logic             rw_q, rw_nxt;
  logic             cnt_zero;

  assign cnt_zero = (cnt == '0);

  always_ff @(posedge clock) begin
    if (clear) begin
      state <= IDLE;
      cnt   <= '0;
      rw_q  <= 1'b0;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      rw_q  <= rw_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    rw_nxt    = rw_q;
    case (state)
      IDLE: if (start) begin
        rw_nxt    = rw;
        state_nxt = LOAD_MAR;
      end
      LOAD_MAR: begin
        cnt_nxt   = CNT_INIT;
        state_nxt = rw_q ? RD_WAIT : WR_LOAD;
      end
      RD_WAIT: begin
        if (cnt_zero) state_nxt = RD_DONE;
        else          cnt_nxt   = cnt - 1'b1;
      end
      RD_DONE: state_nxt = IDLE;
      // Write path reloads here so the wait count starts after MDR has the store data.
      WR_LOAD: begin
        cnt_nxt   = CNT_INIT;
        state_nxt = WR_WAIT;
      end
      WR_WAIT: begin
        if (cnt_zero) state_nxt = WR_DONE;
        else          cnt_nxt   = cnt - 1'b1;
      end
      WR_DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    busy      = (state != IDLE);
    done      = 1'b0;
    MARin     = 1'b0;
    MDRin     = 1'b0;
    read      = 1'b0;
    mem_read  = 1'b0;
    mem_write = 1'b0;
    MDRout    = 1'b0;
    case (state)
      LOAD_MAR: MARin = 1'b1;
      RD_WAIT: begin
        mem_read = 1'b1;
        MDRin    = cnt_zero;
        read     = cnt_zero;
      end
      RD_DONE: begin
        MDRout = 1'b1;
        done   = 1'b1;
      end
      WR_LOAD: MDRin = 1'b1;
      WR_WAIT: mem_write = 1'b1;
      WR_DONE: done = 1'b1;
      default: ;
    endcase
  end

endmodule
